// File: rtl/snake_multi_move_pkg.sv
// rtl/snake_multi_move_pkg.sv - shared types and helpers for the multi-snake engine
// Provides: dir_t, pos_t, step_t, opposite(), step_pos().
package snake_multi_move_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Coordinates are stored at a fixed width so maps up to 255x255 fit;
  // the all-ones cell is never on a legal map and marks "left the map".
  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  typedef struct packed {
    pos_t pos;
    logic oob;
  } step_t;

  // Encoding puts opposite directions two apart.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic step_t step_pos(input pos_t p, input dir_t d, input int map_w,
                                     input int map_h, input logic wrap);
    step_t r;
    r.pos = p;
    r.oob = 1'b0;
    case (d)
      DIR_RIGHT: begin
        if (p.x == COORD_W'(map_w - 1)) begin
          r.pos.x = '0;
          r.oob   = !wrap;
        end else r.pos.x = p.x + 1'b1;
      end
      DIR_LEFT: begin
        if (p.x == '0) begin
          r.pos.x = COORD_W'(map_w - 1);
          r.oob   = !wrap;
        end else r.pos.x = p.x - 1'b1;
      end
      DIR_DOWN: begin
        if (p.y == COORD_W'(map_h - 1)) begin
          r.pos.y = '0;
          r.oob   = !wrap;
        end else r.pos.y = p.y + 1'b1;
      end
      default: begin
        if (p.y == '0) begin
          r.pos.y = COORD_W'(map_h - 1);
          r.oob   = !wrap;
        end else r.pos.y = p.y - 1'b1;
      end
    endcase
    // An off-map head must never match a body cell or another head.
    if (r.oob) r.pos = '1;
    return r;
  endfunction

endpackage

// File: rtl/snake_multi_move_if.sv
// rtl/snake_multi_move_if.sv - control, status and segment-read bundle of the snake engine
// master: tick, dir, food_x/y, rd_player, rd_idx out; status and read data in.
// slave : the engine side.
interface snake_multi_move_if #(
  parameter int PLAYERS = 2,
  parameter int MAX_LEN = 32,
  parameter int MAP_W   = 32,
  parameter int MAP_H   = 24
);
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int MW = $clog2(MAX_LEN);
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

  logic                                      tick;
  snake_multi_move_pkg::dir_t [PLAYERS-1:0]  dir;
  logic [XW-1:0]                             food_x;
  logic [YW-1:0]                             food_y;
  logic                                      busy;
  logic                                      done;
  logic                                      overrun;
  logic [PLAYERS-1:0]                        alive;
  logic [PLAYERS-1:0]                        ate;
  logic [PLAYERS-1:0][LW-1:0]                len;
  logic [PW-1:0]                             rd_player;
  logic [MW-1:0]                             rd_idx;
  logic [XW-1:0]                             rd_x;
  logic [YW-1:0]                             rd_y;
  logic                                      rd_valid;

  modport master (
    output tick, dir, food_x, food_y, rd_player, rd_idx,
    input  busy, done, overrun, alive, ate, len, rd_x, rd_y, rd_valid
  );

  modport slave (
    input  tick, dir, food_x, food_y, rd_player, rd_idx,
    output busy, done, overrun, alive, ate, len, rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_body_ram.sv
// rtl/snake_body_ram.sv - circular segment buffer for one snake
// Ports: clk, rst (async active-low); rd_idx -> rd_pos (registered);
// sc_idx -> sc_pos (combinational scan read); head_pos; push/push_pos prepend a head.
module snake_body_ram
  import snake_multi_move_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int Y0       = 8,
  localparam int MW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [MW-1:0] rd_idx,
  output pos_t          rd_pos,
  input  logic [MW-1:0] sc_idx,
  output pos_t          sc_pos,
  output pos_t          head_pos,
  input  logic          push,
  input  pos_t          push_pos
);
  pos_t          mem_q [MAX_LEN];
  logic [MW-1:0] ptr_q, ptr_d;
  pos_t          rd_pos_q;

  // Segment i lives at ptr+i; a new head goes one slot before the old head,
  // so the oldest segment is overwritten only once the buffer is full.
  always_comb begin
    ptr_d = ptr_q;
    if (push) ptr_d = ptr_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      rd_pos_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i].x <= (i < INIT_LEN) ? COORD_W'(INIT_LEN - 1 - i) : COORD_W'(0);
        mem_q[i].y <= COORD_W'(Y0);
      end
    end else begin
      ptr_q    <= ptr_d;
      rd_pos_q <= mem_q[ptr_q + rd_idx];
      if (push) mem_q[ptr_d] <= push_pos;
    end
  end

  assign rd_pos   = rd_pos_q;
  assign sc_pos   = mem_q[ptr_q + sc_idx];
  assign head_pos = mem_q[ptr_q];
endmodule

// File: rtl/snake_multi_move.sv
// rtl/snake_multi_move.sv - N-player snake move engine with collision resolution
// Ports: clk, rst (async active-low), bus (snake_multi_move_if.slave):
// tick/dir/food in; busy/done/overrun/alive/ate/len out; registered segment read port.
module snake_multi_move
  import snake_multi_move_pkg::*;
#(
  parameter int PLAYERS  = 2,
  parameter int MAX_LEN  = 32,
  parameter int MAP_W    = 32,
  parameter int MAP_H    = 24,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1
) (
  input logic               clk,
  input logic               rst,
  snake_multi_move_if.slave bus
);
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int MW = $clog2(MAX_LEN);
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_SCAN, S_COMMIT} state_t;

  state_t                     st_q, st_d;
  logic [PW-1:0]              hp_q, hp_d, sp_q, sp_d;
  logic [MW-1:0]              si_q, si_d;
  dir_t [PLAYERS-1:0]         cur_dir_q, cur_dir_d;
  logic [PLAYERS-1:0]         alive_q, alive_d, pend_q, pend_d;
  logic [PLAYERS-1:0]         dying_q, dying_d, grow_q, grow_d;
  pos_t [PLAYERS-1:0]         nh_q, nh_d;
  logic [PLAYERS-1:0][LW-1:0] len_q, len_d;
  logic                       overrun_q, overrun_d;
  logic [PW-1:0]              rd_player_q, rd_player_d;
  logic                       rd_valid_q, rd_valid_d;

  pos_t [PLAYERS-1:0] head_pos, sc_pos, rd_pos_p;
  logic [PLAYERS-1:0] push, headon, kill;
  pos_t               food, rd_pos;
  dir_t               req;
  step_t              step;
  logic               scan_hit;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_body
    snake_body_ram #(
      .MAX_LEN (MAX_LEN),
      .INIT_LEN(INIT_LEN),
      .Y0      ((p + 1) * MAP_H / (PLAYERS + 1))
    ) u_body (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (bus.rd_idx),
      .rd_pos  (rd_pos_p[p]),
      .sc_idx  (si_q),
      .sc_pos  (sc_pos[p]),
      .head_pos(head_pos[p]),
      .push    (push[p]),
      .push_pos(nh_q[p])
    );
  end

  assign food = '{x: COORD_W'(bus.food_x), y: COORD_W'(bus.food_y)};

  // Head-on: any two pending heads on one cell kill both owners.
  always_comb begin
    headon = '0;
    for (int a = 0; a < PLAYERS; a++)
      for (int b = 0; b < PLAYERS; b++)
        if (a != b && pend_q[a] && pend_q[b] && nh_q[a] == nh_q[b]) headon[a] = 1'b1;
    kill = dying_q | headon;
    push = (st_q == S_COMMIT) ? (pend_q & ~kill) : '0;
  end

  always_comb begin
    st_d = st_q;  hp_d = hp_q;  sp_d = sp_q;  si_d = si_q;
    cur_dir_d = cur_dir_q;  alive_d = alive_q;  pend_d = pend_q;
    dying_d = dying_q;  grow_d = grow_q;  nh_d = nh_q;  len_d = len_q;
    overrun_d = overrun_q;
    req = DIR_RIGHT;  step = '0;  scan_hit = 1'b0;

    if (bus.tick && st_q != S_IDLE) overrun_d = 1'b1;

    case (st_q)
      S_IDLE: begin
        if (bus.tick) begin
          st_d = S_HEAD;  hp_d = '0;
          pend_d = '0;  dying_d = '0;  grow_d = '0;
        end
      end
      S_HEAD: begin
        if (alive_q[hp_q]) begin
          req = bus.dir[hp_q];
          if (req == opposite(cur_dir_q[hp_q])) req = cur_dir_q[hp_q];
          cur_dir_d[hp_q] = req;
          step            = step_pos(head_pos[hp_q], req, MAP_W, MAP_H, WRAP != 0);
          nh_d[hp_q]      = step.pos;
          pend_d[hp_q]    = 1'b1;
          dying_d[hp_q]   = step.oob;
          grow_d[hp_q]    = (step.pos == food);
        end
        if (hp_q == PW'(PLAYERS - 1)) begin
          st_d = S_SCAN;  sp_d = '0;  si_d = '0;
        end else hp_d = hp_q + 1'b1;
      end
      S_SCAN: begin
        // Dead players or exhausted bodies cost one idle cycle and move on.
        scan_hit = alive_q[sp_q] && (LW'(si_q) < len_q[sp_q]);
        if (scan_hit)
          for (int q = 0; q < PLAYERS; q++)
            if (pend_q[q] && nh_q[q] == sc_pos[sp_q]) dying_d[q] = 1'b1;
        if (!scan_hit || LW'(si_q) == len_q[sp_q] - LW'(1)) begin
          si_d = '0;
          if (sp_q == PW'(PLAYERS - 1)) st_d = S_COMMIT;
          else sp_d = sp_q + 1'b1;
        end else si_d = si_q + 1'b1;
      end
      default: begin
        for (int p = 0; p < PLAYERS; p++)
          if (pend_q[p]) begin
            if (kill[p]) alive_d[p] = 1'b0;
            else if (grow_q[p] && len_q[p] != LW'(MAX_LEN)) len_d[p] = len_q[p] + 1'b1;
          end
        st_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_player_d = bus.rd_player;
    rd_valid_d  = 1'b0;
    if (int'(bus.rd_player) < PLAYERS)
      rd_valid_d = alive_q[bus.rd_player] && (LW'(bus.rd_idx) < len_q[bus.rd_player]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= S_IDLE;  hp_q <= '0;  sp_q <= '0;  si_q <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        cur_dir_q[p] <= DIR_RIGHT;
        len_q[p]     <= LW'(INIT_LEN);
      end
      alive_q <= '1;  pend_q <= '0;  dying_q <= '0;  grow_q <= '0;  nh_q <= '0;
      overrun_q <= 1'b0;  rd_player_q <= '0;  rd_valid_q <= 1'b0;
    end else begin
      st_q <= st_d;  hp_q <= hp_d;  sp_q <= sp_d;  si_q <= si_d;
      cur_dir_q <= cur_dir_d;  len_q <= len_d;
      alive_q <= alive_d;  pend_q <= pend_d;  dying_q <= dying_d;  grow_q <= grow_d;
      nh_q <= nh_d;  overrun_q <= overrun_d;
      rd_player_q <= rd_player_d;  rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_pos = rd_pos_p[rd_player_q];

  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_pos;

  assign bus.busy     = (st_q != S_IDLE);
  assign bus.done     = (st_q == S_COMMIT);
  assign bus.ate      = (st_q == S_COMMIT) ? (pend_q & ~kill & grow_q) : '0;
  assign bus.overrun  = overrun_q;
  assign bus.alive    = alive_q;
  assign bus.len      = len_q;
  assign bus.rd_x     = rd_pos.x[XW-1:0];
  assign bus.rd_y     = rd_pos.y[YW-1:0];
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_snake_multi_move.sv
// tb/tb_snake_multi_move.sv - directed self-checking bench for snake_multi_move
module tb_snake_multi_move;
  import snake_multi_move_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  dir_t [1:0] dirs;
  logic [4:0] fx = 5'd31, fy = 5'd0;
  logic       rd_player = 1'b0;
  logic [4:0] rd_idx = 5'd0;

  int   errors = 0;
  int   checks = 0;
  logic [1:0] ate_cap;
  logic       w_done_seen;
  int   dn;

  always #5 clk = ~clk;

  snake_multi_move_if #(.PLAYERS(2), .MAX_LEN(32), .MAP_W(32), .MAP_H(24)) bus_a ();
  snake_multi_move_if #(.PLAYERS(2), .MAX_LEN(32), .MAP_W(32), .MAP_H(24)) bus_w ();

  assign bus_a.tick = tick;       assign bus_w.tick = tick;
  assign bus_a.dir = dirs;        assign bus_w.dir = dirs;
  assign bus_a.food_x = fx;       assign bus_w.food_x = fx;
  assign bus_a.food_y = fy;       assign bus_w.food_y = fy;
  assign bus_a.rd_player = rd_player;  assign bus_w.rd_player = rd_player;
  assign bus_a.rd_idx = rd_idx;   assign bus_w.rd_idx = rd_idx;

  snake_multi_move #(.PLAYERS(2), .MAX_LEN(32), .MAP_W(32), .MAP_H(24), .INIT_LEN(3), .WRAP(1))
    u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  snake_multi_move #(.PLAYERS(2), .MAX_LEN(32), .MAP_W(32), .MAP_H(24), .INIT_LEN(3), .WRAP(0))
    u_dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input int p, input int idx,
                         input int ex, input int ey, input logic ev);
    rd_player = 1'(p);
    rd_idx    = 5'(idx);
    @(negedge clk);
    check({tag, "_v"}, 32'(bus_a.rd_valid), 32'(ev));
    if (ev) begin
      check({tag, "_x"}, 32'(bus_a.rd_x), ex);
      check({tag, "_y"}, 32'(bus_a.rd_y), ey);
    end
  endtask

  task automatic do_tick(input dir_t a, input dir_t b);
    bit got;
    dirs[0] = a;
    dirs[1] = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    got = 1'b0;
    ate_cap = '0;
    w_done_seen = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus_w.done) w_done_seen = 1'b1;
      if (bus_a.done) begin
        got = 1'b1;
        ate_cap = bus_a.ate;
      end else @(negedge clk);
    end
    check("step_done", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    dirs[0] = DIR_RIGHT;
    dirs[1] = DIR_RIGHT;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_overrun", 32'(bus_a.overrun), 32'd0);
    check("rst_ate", 32'(bus_a.ate), 32'd0);
    check("rst_alive", 32'(bus_a.alive), 32'd3);
    check("rst_len0", 32'(bus_a.len[0]), 32'd3);
    check("rst_len1", 32'(bus_a.len[1]), 32'd3);
    chk_seg("rst_p0_0", 0, 0, 2, 8, 1'b1);
    chk_seg("rst_p0_1", 0, 1, 1, 8, 1'b1);
    chk_seg("rst_p0_2", 0, 2, 0, 8, 1'b1);
    chk_seg("rst_p0_3", 0, 3, 0, 0, 1'b0);
    chk_seg("rst_p1_0", 1, 0, 2, 16, 1'b1);

    fx = 5'd3; fy = 5'd8;
    do_tick(DIR_RIGHT, DIR_RIGHT);
    check("grow_ate", 32'(ate_cap), 32'd1);
    check("grow_len0", 32'(bus_a.len[0]), 32'd4);
    check("grow_len1", 32'(bus_a.len[1]), 32'd3);
    chk_seg("grow_h", 0, 0, 3, 8, 1'b1);
    chk_seg("grow_t", 0, 3, 0, 8, 1'b1);
    chk_seg("grow_4", 0, 4, 0, 0, 1'b0);
    fx = 5'd31; fy = 5'd0;
    do_tick(DIR_RIGHT, DIR_RIGHT);
    check("nogrow_ate", 32'(ate_cap), 32'd0);
    check("nogrow_len0", 32'(bus_a.len[0]), 32'd4);
    chk_seg("nogrow_h", 0, 0, 4, 8, 1'b1);

    for (int i = 0; i < 27; i++) do_tick(DIR_RIGHT, DIR_RIGHT);
    chk_seg("edge_p0", 0, 0, 31, 8, 1'b1);
    chk_seg("edge_p1", 1, 0, 31, 16, 1'b1);
    check("edge_w_alive", 32'(bus_w.alive), 32'd3);
    do_tick(DIR_RIGHT, DIR_RIGHT);
    check("wrap_alive", 32'(bus_a.alive), 32'd3);
    chk_seg("wrap_h", 0, 0, 0, 8, 1'b1);
    chk_seg("wrap_1", 0, 1, 31, 8, 1'b1);
    check("wall_alive", 32'(bus_w.alive), 32'd0);
    check("wall_len0", 32'(bus_w.len[0]), 32'd4);
    check("wall_len1", 32'(bus_w.len[1]), 32'd3);

    do_tick(DIR_LEFT, DIR_RIGHT);
    check("all_dead_done", 32'(w_done_seen), 32'd1);
    chk_seg("rev_h", 0, 0, 1, 8, 1'b1);
    do_tick(DIR_UP, DIR_RIGHT);
    chk_seg("up_h", 0, 0, 1, 7, 1'b1);
    chk_seg("up_p1", 1, 0, 2, 16, 1'b1);

    do_tick(DIR_RIGHT, DIR_DOWN);
    for (int i = 0; i < 8; i++) do_tick(DIR_RIGHT, DIR_RIGHT);
    for (int i = 0; i < 4; i++) do_tick(DIR_DOWN, DIR_UP);
    check("pre_hit_alive", 32'(bus_a.alive), 32'd3);
    chk_seg("pre_hit_p0", 0, 0, 10, 11, 1'b1);
    chk_seg("pre_hit_p1", 1, 0, 10, 13, 1'b1);
    do_tick(DIR_DOWN, DIR_UP);
    check("headon_alive", 32'(bus_a.alive), 32'd0);
    check("headon_ate", 32'(ate_cap), 32'd0);
    check("headon_len0", 32'(bus_a.len[0]), 32'd4);
    check("headon_len1", 32'(bus_a.len[1]), 32'd3);
    chk_seg("headon_rd", 0, 0, 0, 0, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_alive", 32'(bus_a.alive), 32'd3);
    chk_seg("rst2_h", 0, 0, 2, 8, 1'b1);

    dirs[0] = DIR_RIGHT;
    dirs[1] = DIR_RIGHT;
    dn = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.done) dn++;
      @(negedge clk);
    end
    check("ovr_commits", 32'(dn), 32'd1);
    check("ovr_flag", 32'(bus_a.overrun), 32'd1);
    check("ovr_busy", 32'(bus_a.busy), 32'd0);
    chk_seg("ovr_h", 0, 0, 3, 8, 1'b1);

    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("scan_busy", 32'(bus_a.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    check("mid_rst_overrun", 32'(bus_a.overrun), 32'd0);
    check("mid_rst_len0", 32'(bus_a.len[0]), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_seg("mid_rst_h", 0, 0, 2, 8, 1'b1);
    chk_seg("mid_rst_1", 0, 1, 1, 8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
